// File: rtl/cu_pkg.sv
// Shared types for the sequenced control unit: opcode values, FSM states and
// the 10-field control bundle (field order matches the decode table).
package cu_pkg;
  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_AND   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_J     = 4;
  localparam int unsigned OP_BEQ   = 5;
  localparam int unsigned OP_MOV   = 6;
  localparam int unsigned OP_LOADI = 7;
  localparam int unsigned OP_BNE   = 8;
  localparam int unsigned OP_SLL   = 9;
  localparam int unsigned OP_SRL   = 10;
  localparam int unsigned OP_SRA   = 11;
  localparam int unsigned OP_ROR   = 12;
  localparam int unsigned OP_LWD   = 13;
  localparam int unsigned OP_LWI   = 14;
  localparam int unsigned OP_SWD   = 15;
  localparam int unsigned OP_SWI   = 16;

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

  typedef struct packed {
    logic       sel1;
    logic       sel2;
    logic [2:0] aluop;
    logic       we;
    logic       beq;
    logic       j;
    logic       bne;
    logic       rd;
    logic       wr;
    logic       sel4;
  } ctl_t;

  localparam ctl_t CTL_SAFE = '0;
endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: control bundle, width-adjusted ALUOP and a
// legal flag. Illegal opcodes decode to the all-zero safe bundle.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int NUM_OPS  = 17,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctl_t                ctl,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                legal
);
  logic [31:0] opx;

  always_comb begin
    opx   = 32'(opcode);
    legal = opx < 32'(NUM_OPS);
    ctl   = CTL_SAFE;
    if (legal) begin
      // {S1, S2, ALUOP, WE, BEQ, J, BNE, RD, WR, S4}
      case (opx)
        OP_ADD:   ctl = ctl_t'({1'b0, 1'b1, 3'd1, 7'b1000000});
        OP_SUB:   ctl = ctl_t'({1'b1, 1'b1, 3'd1, 7'b1000000});
        OP_AND:   ctl = ctl_t'({1'b0, 1'b1, 3'd2, 7'b1000000});
        OP_OR:    ctl = ctl_t'({1'b0, 1'b1, 3'd3, 7'b1000000});
        OP_J:     ctl = ctl_t'({1'b0, 1'b1, 3'd0, 7'b0010000});
        OP_BEQ:   ctl = ctl_t'({1'b1, 1'b1, 3'd1, 7'b0100000});
        OP_MOV:   ctl = ctl_t'({1'b0, 1'b1, 3'd0, 7'b1000000});
        OP_LOADI: ctl = ctl_t'({1'b0, 1'b0, 3'd0, 7'b1000000});
        OP_BNE:   ctl = ctl_t'({1'b1, 1'b1, 3'd1, 7'b0001000});
        OP_SLL:   ctl = ctl_t'({1'b0, 1'b0, 3'd4, 7'b1000000});
        OP_SRL:   ctl = ctl_t'({1'b0, 1'b0, 3'd5, 7'b1000000});
        OP_SRA:   ctl = ctl_t'({1'b0, 1'b0, 3'd6, 7'b1000000});
        OP_ROR:   ctl = ctl_t'({1'b0, 1'b0, 3'd7, 7'b1000000});
        OP_LWD:   ctl = ctl_t'({1'b0, 1'b1, 3'd0, 7'b1000101});
        OP_LWI:   ctl = ctl_t'({1'b0, 1'b0, 3'd0, 7'b1000101});
        OP_SWD:   ctl = ctl_t'({1'b0, 1'b1, 3'd0, 7'b0000011});
        OP_SWI:   ctl = ctl_t'({1'b0, 1'b0, 3'd0, 7'b0000011});
        default:  ctl = CTL_SAFE;
      endcase
    end
    aluop = ALUOP_W'(ctl.aluop);
  end
endmodule

// File: rtl/controlunit_seq.sv
// Registered control unit: decodes INSTRUCTION into a one-cycle-latency
// output register and sequences the data-memory handshake with a timeout.
module controlunit_seq
  import cu_pkg::*;
#(
  parameter int OPCODE_W        = 8,
  parameter int ALUOP_W         = 3,
  parameter int NUM_OPS         = 17,
  parameter int MEM_TIMEOUT     = 255,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        INSTRUCTION,
  input  logic               I_BUSYWAIT,
  input  logic               D_BUSYWAIT,
  output logic               SELECT1,
  output logic               SELECT2,
  output logic               SELECT4,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               WRITEENABLE,
  output logic               BEQSIGNAL,
  output logic               BNESIGNAL,
  output logic               JSIGNAL,
  output logic               READ,
  output logic               WRITE,
  output logic               PC_STALL,
  output logic               ERROR
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t             state, iss_state;
  logic [CW-1:0]      cnt;
  ctl_t               dec, ctl_q, iss_ctl;
  logic [ALUOP_W-1:0] dec_aluop, aluop_q, iss_aluop;
  logic               legal, iss_err, err_q;
  logic               unused_bits;

  cu_decode #(.OPCODE_W(OPCODE_W), .NUM_OPS(NUM_OPS), .ALUOP_W(ALUOP_W)) u_dec (
    .opcode (INSTRUCTION[31 -: OPCODE_W]),
    .ctl    (dec),
    .aluop  (dec_aluop),
    .legal  (legal)
  );

  // Issue rules shared by RUN and by a MEM_WAIT exit (back-to-back issue).
  always_comb begin
    iss_state = RUN;
    iss_ctl   = CTL_SAFE;
    iss_aluop = '0;
    iss_err   = 1'b0;
    if (!I_BUSYWAIT) begin
      if (legal) begin
        iss_ctl   = dec;
        iss_aluop = dec_aluop;
        if (dec.rd || dec.wr) iss_state = MEM_WAIT;
      end else if (TRAP_ON_ILLEGAL != 0) begin
        iss_state = TRAP;
        iss_err   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= RUN;
      cnt     <= '0;
      ctl_q   <= CTL_SAFE;
      aluop_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          state   <= iss_state;
          ctl_q   <= iss_ctl;
          aluop_q <= iss_aluop;
          cnt     <= '0;
          if (iss_err) err_q <= 1'b1;
        end
        MEM_WAIT: begin
          // cnt != 0 guarantees at least one full wait cycle before release
          if (!D_BUSYWAIT && cnt != '0) begin
            state   <= iss_state;
            ctl_q   <= iss_ctl;
            aluop_q <= iss_aluop;
            cnt     <= '0;
            if (iss_err) err_q <= 1'b1;
          end else begin
            if (cnt != CW'(MEM_TIMEOUT)) cnt <= cnt + CW'(1);
            if (D_BUSYWAIT && cnt == CW'(MEM_TIMEOUT - 1)) begin
              state   <= TRAP;
              ctl_q   <= CTL_SAFE;
              aluop_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          ctl_q   <= CTL_SAFE;
          aluop_q <= '0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign SELECT1     = ctl_q.sel1;
  assign SELECT2     = ctl_q.sel2;
  assign SELECT4     = ctl_q.sel4;
  assign ALUOP       = aluop_q;
  assign WRITEENABLE = ctl_q.we;
  assign BEQSIGNAL   = ctl_q.beq;
  assign BNESIGNAL   = ctl_q.bne;
  assign JSIGNAL     = ctl_q.j;
  assign READ        = ctl_q.rd;
  assign WRITE       = ctl_q.wr;
  assign ERROR       = err_q;
  assign PC_STALL    = (state != RUN) || I_BUSYWAIT;

  assign unused_bits = ^{INSTRUCTION[31-OPCODE_W:0], ctl_q.aluop};
endmodule

// File: tb/tb_controlunit_seq.sv
// Directed bench: decode table vectors plus hand-written handshake, timeout,
// illegal-opcode and async-reset sequences on two parameter variants.
module tb_controlunit_seq;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        I_BUSYWAIT = 1'b0;
  logic        D_BUSYWAIT = 1'b0;

  logic [1:0]      s1, s2, s4, we, beq, bne, jj, rd, wr, stall, err;
  logic [1:0][2:0] alu;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  // u0 traps on illegal opcodes, u1 treats them as NOP; both time out after 8
  controlunit_seq #(.MEM_TIMEOUT(8), .TRAP_ON_ILLEGAL(1)) u0 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .I_BUSYWAIT(I_BUSYWAIT), .D_BUSYWAIT(D_BUSYWAIT),
    .SELECT1(s1[0]), .SELECT2(s2[0]), .SELECT4(s4[0]), .ALUOP(alu[0]),
    .WRITEENABLE(we[0]), .BEQSIGNAL(beq[0]), .BNESIGNAL(bne[0]), .JSIGNAL(jj[0]),
    .READ(rd[0]), .WRITE(wr[0]), .PC_STALL(stall[0]), .ERROR(err[0])
  );

  controlunit_seq #(.MEM_TIMEOUT(8), .TRAP_ON_ILLEGAL(0)) u1 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .I_BUSYWAIT(I_BUSYWAIT), .D_BUSYWAIT(D_BUSYWAIT),
    .SELECT1(s1[1]), .SELECT2(s2[1]), .SELECT4(s4[1]), .ALUOP(alu[1]),
    .WRITEENABLE(we[1]), .BEQSIGNAL(beq[1]), .BNESIGNAL(bne[1]), .JSIGNAL(jj[1]),
    .READ(rd[1]), .WRITE(wr[1]), .PC_STALL(stall[1]), .ERROR(err[1])
  );

  // {S1,S2,ALUOP,WE,BEQ,J,BNE,RD,WR,S4,PC_STALL,ERROR}
  function automatic logic [13:0] obs(int i);
    return {s1[i], s2[i], alu[i], we[i], beq[i], jj[i], bne[i], rd[i], wr[i], s4[i],
            stall[i], err[i]};
  endfunction

  task automatic chk(string name, logic [13:0] got, logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setop(logic [7:0] op);
    INSTRUCTION = {op, 24'h5a5a5a};
  endtask

  localparam logic [13:0] V_ADD  = 14'b01_001_1000000_00;
  localparam logic [13:0] V_MOV  = 14'b01_000_1000000_00;
  localparam logic [13:0] V_LDI  = 14'b00_000_1000000_00;
  localparam logic [13:0] V_LWD  = 14'b01_000_1000101_10;
  localparam logic [13:0] V_LWI  = 14'b00_000_1000101_10;
  localparam logic [13:0] V_SWD  = 14'b01_000_0000011_10;
  localparam logic [13:0] V_SWI  = 14'b00_000_0000011_10;
  localparam logic [13:0] V_TRAP = 14'b00_000_0000000_11;
  localparam logic [13:0] V_ZERO = 14'b00_000_0000000_00;

  typedef struct {
    logic [7:0]  op;
    logic        ib;
    logic [13:0] exp;
    string       name;
  } vec_t;

  vec_t tv[14];

  initial begin
    tv[0]  = '{8'd0,  1'b0, 14'b01_001_1000000_00, "add"};
    tv[1]  = '{8'd1,  1'b0, 14'b11_001_1000000_00, "sub"};
    tv[2]  = '{8'd2,  1'b0, 14'b01_010_1000000_00, "and"};
    tv[3]  = '{8'd3,  1'b0, 14'b01_011_1000000_00, "or"};
    tv[4]  = '{8'd4,  1'b0, 14'b01_000_0010000_00, "j"};
    tv[5]  = '{8'd5,  1'b0, 14'b11_001_0100000_00, "beq"};
    tv[6]  = '{8'd6,  1'b0, 14'b01_000_1000000_00, "mov"};
    tv[7]  = '{8'd7,  1'b0, 14'b00_000_1000000_00, "loadi"};
    tv[8]  = '{8'd8,  1'b0, 14'b11_001_0001000_00, "bne"};
    tv[9]  = '{8'd9,  1'b0, 14'b00_100_1000000_00, "sll"};
    tv[10] = '{8'd10, 1'b0, 14'b00_101_1000000_00, "srl"};
    tv[11] = '{8'd11, 1'b0, 14'b00_110_1000000_00, "sra"};
    tv[12] = '{8'd12, 1'b0, 14'b00_111_1000000_00, "ror"};
    tv[13] = '{8'd3,  1'b1, 14'b00_000_0000000_10, "ibusy_safe"};

    // reset state
    #3;
    chk("reset_outputs", obs(0), V_ZERO);
    I_BUSYWAIT = 1'b1;
    #1;
    chk("reset_stall_follows_ibusy", obs(0), 14'b00_000_0000000_10);
    I_BUSYWAIT = 1'b0;
    RESET = 1'b1;

    // decode table
    for (int i = 0; i < 14; i++) begin
      setop(tv[i].op);
      I_BUSYWAIT = tv[i].ib;
      step();
      chk(tv[i].name, obs(0), tv[i].exp);
    end
    I_BUSYWAIT = 1'b0;

    // lwd with 5 busy cycles: READ held 6 cycles, next op decoded at release
    setop(8'd13); D_BUSYWAIT = 1'b1;
    step();
    chk("lwd_issue", obs(0), V_LWD);
    setop(8'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("lwd_wait", obs(0), V_LWD);
    end
    D_BUSYWAIT = 1'b0;
    step();
    chk("lwd_exit_next_decoded", obs(0), V_ADD);

    // swd then swi back-to-back: WRITE never drops, counter restarts
    setop(8'd15); D_BUSYWAIT = 1'b1;
    step();
    chk("swd_issue", obs(0), V_SWD);
    step();
    chk("swd_wait", obs(0), V_SWD);
    D_BUSYWAIT = 1'b0; setop(8'd16);
    step();
    chk("swi_back_to_back", obs(0), V_SWI);
    step();
    chk("swi_min_wait_after_restart", obs(0), V_SWI);
    setop(8'd6);
    step();
    chk("mov_after_swi", obs(0), V_MOV);

    // lwi timeout after 8 wait cycles
    setop(8'd14); D_BUSYWAIT = 1'b1;
    step();
    chk("lwi_issue", obs(0), V_LWI);
    setop(8'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("lwi_wait", obs(0), V_LWI);
    end
    step();
    chk("timeout_trap", obs(0), V_TRAP);
    D_BUSYWAIT = 1'b0;
    step();
    chk("trap_sticky", obs(0), V_TRAP);
    RESET = 1'b0;
    #1;
    chk("trap_cleared_by_reset", obs(0), V_ZERO);
    #1;
    RESET = 1'b1;

    // illegal opcode 0x20 on both variants
    setop(8'h20);
    step();
    chk("illegal_trap", obs(0), V_TRAP);
    chk("illegal_nop", obs(1), V_ZERO);
    setop(8'd7);
    step();
    chk("illegal_nop_then_loadi", obs(1), V_LDI);
    chk("illegal_trap_holds", obs(0), V_TRAP);
    RESET = 1'b0;
    #1;
    RESET = 1'b1;

    // async reset mid MEM_WAIT
    setop(8'd13); D_BUSYWAIT = 1'b1;
    step();
    chk("memwait_issue", obs(0), V_LWD);
    step();
    chk("memwait_hold", obs(0), V_LWD);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_reset_mid_wait", obs(0), V_ZERO);
    RESET = 1'b1;
    setop(8'd0); D_BUSYWAIT = 1'b0;
    step();
    chk("post_reset_decode", obs(0), V_ADD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/controlunit_seq.md
# controlunit_seq

Registered, parametrised successor to the single-cycle control unit. Decodes the 8-bit opcode in INSTRUCTION[31:24] into datapath control signals and owns the data-memory handshake through a state machine, replacing the old negedge-BUSYWAIT release of READ/WRITE. Adds:
- a PC stall output
- a memory-timeout counter
- an illegal-opcode trap

Sits between the instruction cache output and the datapath/data cache.

## Interface
- OPCODE_W, 8: opcode field width, taken from INSTRUCTION[31:32-OPCODE_W].
- ALUOP_W, 3: ALUOP width. Must be ≥3; upper bits beyond 3 are driven 0.
- NUM_OPS, 17: opcodes 0..NUM_OPS-1 are legal. Must be ≤17.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before trap, range 1..65535.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode traps; 0 = treated as NOP.

- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  fetched instruction.
- I_BUSYWAIT  in  1  instruction cache not ready.
- D_BUSYWAIT  in  1  data cache busy.
- SELECT1, SELECT2, SELECT4  out  1 each  datapath mux selects.
- ALUOP  out  ALUOP_W  ALU function.
- WRITEENABLE, BEQSIGNAL, BNESIGNAL, JSIGNAL  out  1 each  register write and branch/jump controls.
- READ, WRITE  out  1 each  data memory request.
- PC_STALL  out  1  hold PC. Combinational: (state≠RUN) | I_BUSYWAIT.
- ERROR  out  1  sticky trap flag.

## Operation
Decode table, in the order S1 S2 ALUOP WE BEQ J BNE RD WR S4:
- 0 add: 0 1 1 1 0 0 0 0 0 0
- 1 sub: 1 1 1 1 0 0 0 0 0 0
- 2 and: 0 1 2 1 0 0 0 0 0 0
- 3 or: 0 1 3 1 0 0 0 0 0 0
- 4 j: 0 1 0 0 0 1 0 0 0 0
- 5 beq: 1 1 1 0 1 0 0 0 0 0
- 6 mov: 0 1 0 1 0 0 0 0 0 0
- 7 loadi: 0 0 0 1 0 0 0 0 0 0
- 8 bne: 1 1 1 0 0 0 1 0 0 0
- 9–12 sll/srl/sra/ror: 0 0 4–7 1 0 0 0 0 0 0
- 13 lwd: 0 1 0 1 0 0 0 1 0 1
- 14 lwi: 0 0 0 1 0 0 0 1 0 1
- 15 swd: 0 1 0 0 0 0 0 0 1 1
- 16 swi: 0 0 0 0 0 0 0 0 1 1

"Safe" output set: all outputs 0.

States:
- **RUN**
  - I_BUSYWAIT=1: outputs load safe; stay in RUN.
  - Otherwise, legal opcode: outputs load its decode.
  - Opcode 13–16: go to MEM_WAIT and clear the counter.
  - Illegal opcode with TRAP_ON_ILLEGAL=1: go to TRAP and set ERROR.
  - Illegal opcode with TRAP_ON_ILLEGAL=0: outputs load safe (NOP).
- **MEM_WAIT**
  - Outputs hold. Counter increments every cycle.
  - Exit on the first edge with D_BUSYWAIT=0 and counter≥1, i.e. at least one full wait cycle. At that edge READ/WRITE clear and the RUN decode rules apply to the current INSTRUCTION (back-to-back issue).
  - Counter reaching MEM_TIMEOUT with D_BUSYWAIT=1: go to TRAP.
- **TRAP**
  - Outputs safe, ERROR=1, PC_STALL=1. Exits only on reset.

Counter width: $clog2(MEM_TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset: state RUN, counter 0, every output 0. PC_STALL then follows I_BUSYWAIT only.
- Decode latency: 1 cycle. INSTRUCTION sampled at edge N drives outputs after edge N.
- READ/WRITE are asserted from the issue edge and held through MEM_WAIT. They drop at the edge where D_BUSYWAIT=0 is sampled (minimum 2-cycle assertion).
- D_BUSYWAIT falling and a new memory opcode at the same edge: READ/WRITE stay asserted for the new op and the counter clears. No dead cycle.
- I_BUSYWAIT=1 during MEM_WAIT: no effect until exit. At exit it forces safe outputs.
- Reset asserted mid-MEM_WAIT: immediately all outputs 0 and state RUN, without waiting for a clock edge.

## Structure
- Package `cu_pkg`:
  - opcode localparams (OP_ADD…OP_SWI);
  - state enum (RUN, MEM_WAIT, TRAP);
  - control-bundle typedef: packed struct of the 10 control fields.
- Sub-module `cu_decode`: purely combinational opcode → bundle plus `legal` flag, parametrised by NUM_OPS/ALUOP_W.
- Top `controlunit_seq`: FSM, counter, output register, PC_STALL logic.

## Test plan
- Reset then op 0 (add) with I_BUSYWAIT=0 → after one edge: S2=1, ALUOP=1, WE=1, others 0, PC_STALL=0.
- Op 13 (lwd), D_BUSYWAIT high for 5 cycles then low → READ=1 and PC_STALL=1 for 6 cycles; READ=0 at the edge after D_BUSYWAIT low is sampled; the next instruction is decoded at that same edge.
- Op 15 (swd) followed immediately by op 16 at exit → WRITE stays 1 continuously; SELECT2 goes 1→0; counter restarts.
- Op 14 with D_BUSYWAIT stuck high, MEM_TIMEOUT=8 → TRAP after 8 wait cycles; ERROR=1, READ=0, PC_STALL=1 until RESET low.
- Opcode 0x20: with TRAP_ON_ILLEGAL=1 → ERROR=1, TRAP; with TRAP_ON_ILLEGAL=0 → all outputs 0 and the next op 7 decodes normally (S2=0, WE=1).
- RESET pulsed low asynchronously during MEM_WAIT → READ=0 before the next CLK edge; state RUN.
